// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the interrupt request latch.
package irq_pkg;

    localparam int unsigned N           = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned HOLDOFF_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/irq_edge_detect.sv
// Per-line request qualification: rising-edge or level, selected by edge_mode.
module irq_edge_detect
    import irq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irq_in,
    input  logic [N-1:0] edge_mode,
    output logic [N-1:0] set_vec_c
);

    logic [N-1:0] irq_q;

    // Clearing to 0 makes a line already high at reset release look like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_in;
        end
    end

    assign set_vec_c = (edge_mode & irq_in & ~irq_q) | (~edge_mode & irq_in);

endmodule

// File: rtl/irq_request_latch.sv
// Pending-bit latch with masked snapshot, ack handling and post-ack hold-off,
// feeding an 8-input priority encoder.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int unsigned HOLDOFF = HOLDOFF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     irq_in,
    input  logic [N-1:0]     edge_mode,
    input  logic [N-1:0]     mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N-1:0]     req_vec,
    output logic             req_en,
    output logic             ack_err,
    output logic [N-1:0]     pending
);

    localparam int unsigned CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     req_vec_q, req_vec_d;
    logic             req_en_q, req_en_d;
    logic             ack_err_q, ack_err_d;
    logic             ack_ok;
    logic [N-1:0]     set_vec_c;

    irq_edge_detect u_edge (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .edge_mode (edge_mode),
        .set_vec_c (set_vec_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            req_vec_q <= '0;
            req_en_q  <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            req_vec_q <= req_vec_d;
            req_en_q  <= req_en_d;
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_vec_d = req_vec_q;
        ack_err_d = 1'b0;
        ack_ok    = 1'b0;

        case (state_q)
            IDLE: begin
                req_vec_d = '0;
                if ((pending_q & mask) != '0) begin
                    req_vec_d = pending_q & mask;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    if (req_vec_q[ack_idx]) begin
                        ack_ok    = 1'b1;
                        req_vec_d = '0;
                        if (HOLDOFF == 0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d   = CNT_W'(HOLDOFF - 1);
                            state_d = HOLD;
                        end
                    end else begin
                        ack_err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                req_vec_d = '0;
            end
        endcase

        // New requests in the same cycle override the clear of a serviced line.
        pending_d = pending_q;
        if (ack_ok) begin
            pending_d[ack_idx] = 1'b0;
        end
        pending_d = pending_d | set_vec_c;

        req_en_d = (state_d == REQ);
    end

    assign req_vec = req_vec_q;
    assign req_en  = req_en_q;
    assign ack_err = ack_err_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench for irq_request_latch (default hold-off and a zero hold-off build).
module tb_irq_request_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in, edge_mode, mask;
    logic       ack, ack0;
    logic [2:0] ack_idx, ack_idx0;
    logic [7:0] req_vec, pending, req_vec0, pending0;
    logic       req_en, ack_err, req_en0, ack_err0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef enum int {S_PEND, S_EN, S_VEC, S_ERR, S_PEND0, S_EN0, S_VEC0} sel_t;
    typedef struct {
        string      tag;
        sel_t       sel;
        logic [7:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    irq_request_latch #(.HOLDOFF(4)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .edge_mode(edge_mode), .mask(mask),
        .ack(ack), .ack_idx(ack_idx), .req_vec(req_vec), .req_en(req_en),
        .ack_err(ack_err), .pending(pending)
    );

    irq_request_latch #(.HOLDOFF(0)) dut0 (
        .clk(clk), .rst(rst), .irq_in(irq_in), .edge_mode(edge_mode), .mask(mask),
        .ack(ack0), .ack_idx(ack_idx0), .req_vec(req_vec0), .req_en(req_en0),
        .ack_err(ack_err0), .pending(pending0)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    endtask

    function automatic logic [7:0] observe(input sel_t sel);
        case (sel)
            S_PEND:  return pending;
            S_EN:    return {7'd0, req_en};
            S_VEC:   return req_vec;
            S_ERR:   return {7'd0, ack_err};
            S_PEND0: return pending0;
            S_EN0:   return {7'd0, req_en0};
            default: return req_vec0;
        endcase
    endfunction

    task automatic expect_v(input string tag, input sel_t sel, input logic [7:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    // Advance one clock and retire every expectation queued for that edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_in = 8'h00; ack = 1'b0; ack0 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; irq_in = 8'hFF; edge_mode = 8'hFF; mask = 8'hFF;
        ack = 1'b0; ack_idx = '0; ack0 = 1'b0; ack_idx0 = '0;
        @(negedge clk);

        // Reset with all lines high, then release.
        expect_v("rst_pend", S_PEND, 8'h00); expect_v("rst_en", S_EN, 8'h00);
        expect_v("rst_vec", S_VEC, 8'h00);   expect_v("rst_err", S_ERR, 8'h00);
        tick();
        expect_v("rst2_pend", S_PEND, 8'h00); expect_v("rst2_en", S_EN, 8'h00);
        tick();
        rst = 1'b0;
        expect_v("rel_pend", S_PEND, 8'hFF); expect_v("rel_en", S_EN, 8'h00);
        tick();
        expect_v("rel_en2", S_EN, 8'h01); expect_v("rel_vec", S_VEC, 8'hFF);
        tick();
        do_reset();

        // Single edge line, service, hold-off.
        irq_in = 8'h20;
        expect_v("e5_pend", S_PEND, 8'h20); expect_v("e5_en0", S_EN, 8'h00);
        tick();
        irq_in = 8'h00;
        expect_v("e5_en", S_EN, 8'h01); expect_v("e5_vec", S_VEC, 8'h20);
        tick();
        ack = 1'b1; ack_idx = 3'd5;
        expect_v("e5_ack_pend", S_PEND, 8'h00); expect_v("e5_ack_en", S_EN, 8'h00);
        expect_v("e5_ack_vec", S_VEC, 8'h00);   expect_v("e5_ack_err", S_ERR, 8'h00);
        tick();
        ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_v($sformatf("e5_hold%0d", i), S_EN, 8'h00);
            tick();
        end

        // Masked snapshot held through a mask change.
        mask = 8'h04; irq_in = 8'h84;
        expect_v("m_pend", S_PEND, 8'h84);
        tick();
        irq_in = 8'h00;
        expect_v("m_en", S_EN, 8'h01); expect_v("m_vec", S_VEC, 8'h04);
        tick();
        mask = 8'hFF;
        expect_v("m_vec_held", S_VEC, 8'h04);
        tick();
        ack = 1'b1; ack_idx = 3'd2;
        expect_v("m_ack_pend", S_PEND, 8'h80); expect_v("m_ack_en", S_EN, 8'h00);
        tick();
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_v($sformatf("m_hold%0d", i), S_EN, 8'h00);
            tick();
        end
        expect_v("m_re_en", S_EN, 8'h01); expect_v("m_re_vec", S_VEC, 8'h80);
        tick();
        ack = 1'b1; ack_idx = 3'd7;
        expect_v("m7_pend", S_PEND, 8'h00);
        tick();
        ack = 1'b0;
        repeat (6) tick();

        // Illegal ack, then a legal one.
        irq_in = 8'h08;
        expect_v("il_pend", S_PEND, 8'h08);
        tick();
        irq_in = 8'h00;
        expect_v("il_vec", S_VEC, 8'h08);
        tick();
        ack = 1'b1; ack_idx = 3'd1;
        expect_v("il_err", S_ERR, 8'h01); expect_v("il_en", S_EN, 8'h01);
        expect_v("il_pend_kept", S_PEND, 8'h08); expect_v("il_vec_kept", S_VEC, 8'h08);
        tick();
        ack = 1'b0;
        expect_v("il_err_off", S_ERR, 8'h00); expect_v("il_en_kept", S_EN, 8'h01);
        tick();
        ack = 1'b1; ack_idx = 3'd3;
        expect_v("il_ok_pend", S_PEND, 8'h00); expect_v("il_ok_en", S_EN, 8'h00);
        expect_v("il_ok_err", S_ERR, 8'h00);
        tick();
        ack = 1'b0;
        repeat (6) tick();

        // Level line held high: set wins over clear.
        edge_mode = 8'h00; irq_in = 8'h01;
        expect_v("lv_pend", S_PEND, 8'h01);
        tick();
        expect_v("lv_vec", S_VEC, 8'h01);
        tick();
        ack = 1'b1; ack_idx = 3'd0;
        expect_v("lv_ack_pend", S_PEND, 8'h01); expect_v("lv_ack_en", S_EN, 8'h00);
        tick();
        ack = 1'b0;
        repeat (4) tick();
        expect_v("lv_re_en", S_EN, 8'h01); expect_v("lv_re_vec", S_VEC, 8'h01);
        tick();

        // Reset while in HOLD with cnt=2.
        ack = 1'b1; ack_idx = 3'd0;
        tick();
        ack = 1'b0;
        tick();
        rst = 1'b1; irq_in = 8'h00;
        expect_v("mr_pend", S_PEND, 8'h00); expect_v("mr_en", S_EN, 8'h00);
        expect_v("mr_vec", S_VEC, 8'h00);   expect_v("mr_err", S_ERR, 8'h00);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_v($sformatf("mr_idle%0d", i), S_EN, 8'h00);
            tick();
        end

        // Zero hold-off build: IDLE right after ack, re-request one edge later.
        edge_mode = 8'hFF;
        do_reset();
        irq_in = 8'h10;
        expect_v("z_pend", S_PEND0, 8'h10);
        tick();
        irq_in = 8'h00;
        expect_v("z_en", S_EN0, 8'h01); expect_v("z_vec", S_VEC0, 8'h10);
        tick();
        ack0 = 1'b1; ack_idx0 = 3'd4; irq_in = 8'h02;
        expect_v("z_ack_pend", S_PEND0, 8'h02); expect_v("z_ack_en", S_EN0, 8'h00);
        tick();
        ack0 = 1'b0; irq_in = 8'h00;
        expect_v("z_re_en", S_EN0, 8'h01); expect_v("z_re_vec", S_VEC0, 8'h02);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
